// File: rtl/rlwe_load_pkg.sv
// Shared constants and helpers for the RLWE operand-load stage.
package rlwe_load_pkg;

   // Per-lane source select encodings
   localparam logic [1:0] SRC_IN    = 2'd0;
   localparam logic [1:0] SRC_MSG   = 2'd1;
   localparam logic [1:0] SRC_GAUSS = 2'd2;
   localparam logic [1:0] SRC_ZERO  = 2'd3;

   // Bit offset of a lane inside a packed lane vector
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/rlwe_load_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head entry.
// The head register is one of the DEPTH entries; the remaining entries
// queue behind it in a circular buffer.
module rlwe_load_fifo #(
   parameter int WIDTH = 84,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] head_q;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;

   logic do_wr;
   logic do_rd;
   logic head_from_wr;
   logic head_from_mem;
   logic mem_wr;

   assign full  = (count_q == CW'(DEPTH));
   assign valid = (count_q != '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && valid;

   // A write lands in the head when the FIFO is empty, or when the only
   // entry is leaving this cycle; otherwise it queues behind the head.
   assign head_from_wr  = do_wr && ((count_q == '0) || (count_q == CW'(1) && do_rd));
   assign head_from_mem = do_rd && (count_q > CW'(1));
   assign mem_wr        = do_wr && !head_from_wr;

   // Control state: head register, pointers, occupancy, sticky overflow
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         head_q     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en && full)
            overflow_q <= 1'b1;
         if (head_from_wr)
            head_q <= wr_data;
         else if (head_from_mem)
            head_q <= mem[rd_ptr];
         if (head_from_mem)
            rd_ptr <= rd_ptr + AW'(1);
         if (mem_wr)
            wr_ptr <= wr_ptr + AW'(1);
         count_q <= count_q + CW'(do_wr) - CW'(do_rd);
      end
   end

   // Backing storage for entries queued behind the head
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; pointers and count
      // define which words are live, so stale contents are never observed.
      if (mem_wr)
         mem[wr_ptr] <= wr_data;
   end

   assign rd_data  = head_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/rlwe_load_stage.sv
// Operand-loading front-end for the RLWE datapath: per-lane source muxes,
// hold registers, a message-bit delay line and an output FIFO.
module rlwe_load_stage
   import rlwe_load_pkg::*;
#(
   parameter int              W       = 30,
   parameter int              LANES   = 2,
   parameter int              DEPTH   = 4,
   parameter int              CTRL_W  = 24,
   parameter int              MSG_LAT = 2,
   parameter logic [W-1:0]    Q_HALF  = W'(30'h1FFF_FFFF),
   localparam int             CW      = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2*LANES-1:0]   src_sel,
   input  logic [LANES-1:0]     lane_en,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*W-1:0]   in_data,
   input  logic [W-1:0]         gsample,
   input  logic                 message_bit,
   input  logic [CTRL_W-1:0]    ctrl_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   out_data,
   output logic [CTRL_W-1:0]    ctrl_out,
   output logic [CW-1:0]        count,
   output logic                 overflow
);

   localparam int FW = LANES * W + CTRL_W;

   logic [W-1:0]       hold_reg [LANES];
   logic [W-1:0]       lane_val [LANES];
   logic [MSG_LAT-1:0] msg_pipe;
   logic [FW-1:0]      wr_data;
   logic [FW-1:0]      rd_data;
   logic               push;
   logic               pop;
   logic               fifo_full;

   // Ready depends only on registered occupancy, never on out_ready
   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   // Message delay line, shifts every cycle independent of the handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         msg_pipe <= '0;
      end else begin
         msg_pipe[0] <= message_bit;
         for (int i = 1; i < MSG_LAT; i++)
            msg_pipe[i] <= msg_pipe[i-1];
      end
   end

   // Lane source muxes and FIFO write-word packing
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned and infers a latch.
      wr_data = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_val[i] = hold_reg[i];
         if (lane_en[i]) begin
            unique case (src_sel[2*i +: 2])
               SRC_IN:    lane_val[i] = in_data[lane_lsb(i, W) +: W];
               SRC_MSG:   lane_val[i] = msg_pipe[MSG_LAT-1] ? Q_HALF : '0;
               SRC_GAUSS: lane_val[i] = gsample;
               SRC_ZERO:  lane_val[i] = '0;
               default:   lane_val[i] = '0;
            endcase
         end
         wr_data[lane_lsb(i, W) +: W] = lane_val[i];
      end
      wr_data[LANES*W +: CTRL_W] = ctrl_in;
   end

   // Hold registers capture the loaded value only on a push
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++)
            hold_reg[i] <= '0;
      end else if (push) begin
         for (int i = 0; i < LANES; i++)
            hold_reg[i] <= lane_val[i];
      end
   end

   rlwe_load_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (push),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (rd_data),
      .valid    (out_valid),
      .full     (fifo_full),
      .count    (count),
      .overflow (overflow)
   );

   assign out_data = rd_data[LANES*W-1:0];
   assign ctrl_out = rd_data[LANES*W +: CTRL_W];

endmodule

// File: tb/tb_rlwe_load_stage.sv
// Directed self-checking bench for rlwe_load_stage (default parameters).
module tb_rlwe_load_stage;

   localparam int W      = 30;
   localparam int LANES  = 2;
   localparam int DEPTH  = 4;
   localparam int CTRL_W = 24;
   localparam logic [W-1:0] QH = 30'h1FFF_FFFF;

   logic                clk = 1'b0;
   logic                rst;
   logic [2*LANES-1:0]  src_sel;
   logic [LANES-1:0]    lane_en;
   logic                in_valid;
   logic                in_ready;
   logic [LANES*W-1:0]  in_data;
   logic [W-1:0]        gsample;
   logic                message_bit;
   logic [CTRL_W-1:0]   ctrl_in;
   logic                out_valid;
   logic                out_ready;
   logic [LANES*W-1:0]  out_data;
   logic [CTRL_W-1:0]   ctrl_out;
   logic [2:0]          count;
   logic                overflow;

   int n_vec  = 0;
   int n_fail = 0;

   rlwe_load_stage dut (
      .clk         (clk),
      .rst         (rst),
      .src_sel     (src_sel),
      .lane_en     (lane_en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .gsample     (gsample),
      .message_bit (message_bit),
      .ctrl_in     (ctrl_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .ctrl_out    (ctrl_out),
      .count       (count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LANES*W-1:0] pack(input logic [W-1:0] l1, input logic [W-1:0] l0);
      return {l1, l0};
   endfunction

   initial begin
      rst = 1'b1; src_sel = '0; lane_en = 2'b11; in_valid = 1'b1;
      in_data = '0; gsample = '0; message_bit = 1'b0; ctrl_in = '0; out_ready = 1'b0;

      // Reset with in_valid asserted
      tick(); tick();
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_count",     count,     0);
      check("rst_out_data",  out_data,  0);
      check("rst_ctrl_out",  ctrl_out,  0);
      check("rst_overflow",  overflow,  0);
      rst = 1'b0; in_valid = 1'b0;
      tick();

      // Basic load
      in_data = pack(30'h2, 30'h1); src_sel = {2'd0, 2'd0}; lane_en = 2'b11;
      ctrl_in = 24'hABCDEF; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("basic_valid", out_valid, 1);
      check("basic_data",  out_data,  pack(30'h2, 30'h1));
      check("basic_ctrl",  ctrl_out,  24'hABCDEF);
      tick();
      check("basic_drain", count, 0);

      // Message and zero sources; second push overlaps a pop at count==1
      message_bit = 1'b1;
      tick();                       // bit captured
      message_bit = 1'b0;
      tick();
      src_sel = {2'd3, 2'd1}; lane_en = 2'b11; ctrl_in = 24'h000011; in_valid = 1'b1;
      tick();                       // push at t+2
      check("msg_one_data", out_data, pack('0, QH));
      ctrl_in = 24'h000012;
      tick();                       // push at t+3 with simultaneous pop
      in_valid = 1'b0;
      check("msg_zero_data", out_data, pack('0, '0));
      check("msg_zero_ctrl", ctrl_out, 24'h000012);
      check("pushpop_count", count, 1);
      tick();
      check("msg_drain", count, 0);

      // Hold registers
      out_ready = 1'b0;
      gsample = 30'h5; src_sel = {2'd2, 2'd2}; lane_en = 2'b11; in_valid = 1'b1;
      tick();
      in_data = pack(30'h7, 30'h7); src_sel = {2'd0, 2'd0}; lane_en = 2'b01;
      tick();
      in_valid = 1'b0;
      check("hold_first",  out_data, pack(30'h5, 30'h5));
      check("hold_count",  count, 2);
      out_ready = 1'b1;
      tick();
      check("hold_second", out_data, pack(30'h5, 30'h7));
      tick();
      check("hold_drain", count, 0);

      // Backpressure until full, then a rejected fifth offer
      out_ready = 1'b0; lane_en = 2'b11; src_sel = '0;
      for (int i = 1; i <= DEPTH; i++) begin
         in_data = pack(W'(i + 16), W'(i)); ctrl_in = CTRL_W'(i); in_valid = 1'b1;
         tick();
      end
      check("full_count",    count, 4);
      check("full_in_ready", in_ready, 0);
      in_data = pack(30'd21, 30'd5); ctrl_in = 24'd5;
      tick();
      in_valid = 1'b0;
      check("full_ignored",  count, 4);
      check("full_no_ovf",   overflow, 0);
      out_ready = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         check($sformatf("drain_data_%0d", i), out_data, pack(W'(i + 16), W'(i)));
         check($sformatf("drain_ctrl_%0d", i), ctrl_out, i);
         tick();
      end
      check("drain_empty", out_valid, 0);

      // Simultaneous push/pop with more than one entry keeps order and count
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = pack('0, 30'd10); tick();
      in_data = pack('0, 30'd11); tick();
      in_data = pack('0, 30'd12); out_ready = 1'b1; tick();
      in_valid = 1'b0;
      check("pp2_count", count, 2);
      check("pp2_head",  out_data, pack('0, 30'd11));
      tick();
      check("pp2_next",  out_data, pack('0, 30'd12));
      tick();

      // Reset while three entries are queued
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = pack('0, W'(40 + i)); tick();
      end
      in_valid = 1'b0;
      check("pre_rst_count", count, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_count",    count, 0);
      check("mid_rst_valid",    out_valid, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_data",     out_data, 0);
      tick();
      check("post_rst_idle",    out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
